// File: rtl/bcd_counter_if.sv
// Control and status bundle for the packed-BCD counter.
// The parent drives control through master; the counter sits on slave.
interface bcd_counter_if #(
  parameter int DIGITS = 3
);
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic                  up;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic                  at_limit;
  logic                  err;

  modport master (
    output clr, load, load_val, en, up,
    input  count, wrap, at_limit, err
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, wrap, at_limit, err
  );
endinterface

// File: rtl/bcd_counter.sv
// Registered N-digit packed-BCD up/down counter with load, clear and a
// wrap-or-saturate end policy. count, wrap and err come straight from flops.
module bcd_counter #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  bcd_counter_if.slave  bus
);
  localparam int             W       = 4 * DIGITS;
  localparam logic [W-1:0]   MAX_VAL = {DIGITS{4'h9}};
  localparam logic [W-1:0]   MIN_VAL = '0;

  logic [W-1:0] count_p0;
  logic         wrap_p0;
  logic         err_p0;

  logic [W-1:0] count_nx;
  logic         wrap_nx;
  logic         err_nx;
  logic         at_term;

  // Zero any digit above 9 so an illegal load never reaches count.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One BCD step with per-digit ripple: a digit moves only while every
  // lower digit rolled over. Terminal values roll naturally to the far end.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic dir_up);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (dir_up) begin
          if (d == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = d + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (d == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = d - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // End-of-range policy: hold in saturate mode, otherwise take the rolled value.
  function automatic logic [W-1:0] limit_step(input logic [W-1:0] v, input logic dir_up,
                                              input logic term);
    if (SATURATE && term) return v;
    return bcd_step(v, dir_up);
  endfunction

  assign at_term = bus.up ? (count_p0 == MAX_VAL) : (count_p0 == MIN_VAL);

  always_comb begin
    count_nx = count_p0;
    wrap_nx  = 1'b0;
    err_nx   = err_p0;
    if (bus.clr) begin
      count_nx = '0;
      err_nx   = 1'b0;
    end else if (bus.load) begin
      count_nx = sanitize(bus.load_val);
      if (has_bad_digit(bus.load_val)) err_nx = 1'b1;
    end else if (bus.en) begin
      count_nx = limit_step(count_p0, bus.up, at_term);
      wrap_nx  = !SATURATE && at_term;
    end
  end

  // Stage p0: the only register stage; outputs are read from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p0 <= '0;
      wrap_p0  <= 1'b0;
      err_p0   <= 1'b0;
    end else begin
      count_p0 <= count_nx;
      wrap_p0  <= wrap_nx;
      err_p0   <= err_nx;
    end
  end

  assign bus.count    = count_p0;
  assign bus.wrap     = wrap_p0;
  assign bus.err      = err_p0;
  assign bus.at_limit = at_term;
endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: 3-digit wrap, 3-digit saturate and
// 4-digit wrap instances share one clock and reset.
module tb_bcd_counter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  bcd_counter_if #(.DIGITS(3)) if_a ();
  bcd_counter_if #(.DIGITS(3)) if_s ();
  bcd_counter_if #(.DIGITS(4)) if_f ();

  bcd_counter #(.DIGITS(3), .SATURATE(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  bcd_counter #(.DIGITS(3), .SATURATE(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(if_s));
  bcd_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_f (.clk(clk), .reset(reset), .bus(if_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  int wraps;
  int mism;
  int model;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    {if_a.clr, if_a.load, if_a.en, if_a.up} = '0;  if_a.load_val = '0;
    {if_s.clr, if_s.load, if_s.en, if_s.up} = '0;  if_s.load_val = '0;
    {if_f.clr, if_f.load, if_f.en, if_f.up} = '0;  if_f.load_val = '0;
    tick();
    tick();
    chk("rst_count_a", if_a.count, 32'h000);
    chk("rst_wrap_a", if_a.wrap, 0);
    chk("rst_err_a", if_a.err, 0);
    chk("rst_atlim_dn_a", if_a.at_limit, 1);
    chk("rst_count_f", if_f.count, 32'h0000);
    reset = 1'b0;

    // Test 1: ripple carry and wrap at MAX
    if_a.load = 1; if_a.load_val = 12'h099;
    tick();
    if_a.load = 0; if_a.en = 1; if_a.up = 1;
    tick();
    chk("inc_099", if_a.count, 32'h100);
    chk("inc_099_wrap", if_a.wrap, 0);
    if_a.en = 0; if_a.load = 1; if_a.load_val = 12'h999;
    tick();
    chk("atlim_max", if_a.at_limit, 1);
    if_a.load = 0; if_a.en = 1;
    tick();
    chk("wrap_up_cnt", if_a.count, 32'h000);
    chk("wrap_up_pulse", if_a.wrap, 1);
    tick();
    chk("after_wrap_cnt", if_a.count, 32'h001);
    chk("after_wrap_pulse", if_a.wrap, 0);
    if_a.en = 0;

    // Test 2: wrap at MIN and a full down cycle
    if_a.clr = 1;
    tick();
    if_a.clr = 0; if_a.en = 1; if_a.up = 0;
    tick();
    chk("wrap_dn_cnt", if_a.count, 32'h999);
    chk("wrap_dn_pulse", if_a.wrap, 1);
    wraps = 0; mism = 0; model = 999;
    for (int i = 0; i < 1000; i++) begin
      tick();
      model = (model == 0) ? 999 : model - 1;
      if (if_a.count !== to_bcd3(model)) mism++;
      if (if_a.wrap) wraps++;
    end
    if_a.en = 0;
    chk("down_seq_mism", mism, 0);
    chk("down_seq_wraps", wraps, 1);
    chk("down_seq_end", if_a.count, 32'h999);

    // Test 3: saturate mode
    if_s.load = 1; if_s.load_val = 12'h998;
    tick();
    if_s.load = 0; if_s.en = 1; if_s.up = 1;
    tick();
    chk("sat_1", if_s.count, 32'h999);
    chk("sat_1_wrap", if_s.wrap, 0);
    chk("sat_1_atlim", if_s.at_limit, 1);
    tick();
    chk("sat_2", if_s.count, 32'h999);
    chk("sat_2_wrap", if_s.wrap, 0);
    tick();
    chk("sat_3", if_s.count, 32'h999);
    chk("sat_3_wrap", if_s.wrap, 0);
    if_s.en = 0; if_s.up = 0;
    #1;
    chk("sat_atlim_dn", if_s.at_limit, 0);
    if_s.en = 1;
    tick();
    chk("sat_dn", if_s.count, 32'h998);
    if_s.en = 0; if_s.clr = 1;
    tick();
    if_s.clr = 0; if_s.en = 1;
    tick();
    chk("sat_min_hold", if_s.count, 32'h000);
    chk("sat_min_wrap", if_s.wrap, 0);
    if_s.en = 0;

    // Test 4: illegal digit load and sticky err
    if_a.load = 1; if_a.load_val = 12'h1A5;
    tick();
    chk("bad_load_cnt", if_a.count, 32'h105);
    chk("bad_load_err", if_a.err, 1);
    if_a.load_val = 12'h042;
    tick();
    chk("clean_load_cnt", if_a.count, 32'h042);
    chk("clean_load_err", if_a.err, 1);
    if_a.load = 0; if_a.clr = 1;
    tick();
    chk("clr_cnt", if_a.count, 32'h000);
    chk("clr_err", if_a.err, 0);
    if_a.clr = 0;

    // Test 5: priority
    if_a.load = 1; if_a.load_val = 12'h500; if_a.en = 1; if_a.up = 1;
    tick();
    chk("load_over_en", if_a.count, 32'h500);
    if_a.clr = 1;
    tick();
    chk("clr_over_load", if_a.count, 32'h000);
    {if_a.clr, if_a.load, if_a.en} = '0;

    // Test 6: 4-digit run, reset mid-run and reset against a wrap
    if_f.load = 1; if_f.load_val = 16'h00F0;
    tick();
    chk("f_bad_load_err", if_f.err, 1);
    if_f.load = 0; if_f.en = 1; if_f.up = 1;
    for (int i = 0; i < 123; i++) tick();
    chk("f_count_123", if_f.count, 32'h0123);
    reset = 1;
    tick();
    reset = 0;
    chk("f_rst_cnt", if_f.count, 32'h0000);
    chk("f_rst_wrap", if_f.wrap, 0);
    chk("f_rst_err", if_f.err, 0);
    if_f.en = 0; if_f.load = 1; if_f.load_val = 16'h9999;
    tick();
    if_f.load = 0; if_f.en = 1;
    tick();
    chk("f_wrap_cnt", if_f.count, 32'h0000);
    chk("f_wrap_pulse", if_f.wrap, 1);
    if_f.en = 0; if_f.load = 1;
    tick();
    if_f.load = 0; if_f.en = 1; reset = 1;
    tick();
    reset = 0; if_f.en = 0;
    chk("f_rst_wrap_cnt", if_f.count, 32'h0000);
    chk("f_rst_wrap_pulse", if_f.wrap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
